// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - program memory read handshake between fetch unit and memory
interface instr_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction register and fetch FSM (optional FETCH_TIMEOUT_EN)
module instr_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned FETCH_TIMEOUT = 8
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       IRin,
  input  logic       PCinc,
  input  logic       PCHin,
  input  logic       PCLin,
  input  logic       PCHout,
  input  logic       PCLout,
  input  logic       IRout,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       bus_conflict,
  instr_fetch_unit_if.master mem,
  output logic [3:0] opcode,
  output logic [1:0] r1_sel,
  output logic [1:0] r2_sel,
  output logic       fetch_busy,
  output logic       ir_valid,
  output logic       fetch_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_inc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // PC next value: a byte load beats increment; a PCL load blocks the carry into PCH
  always_comb begin
    pc_inc = pc_q + 16'd1;
    pc_d   = pc_q;
    if (PCLin)      pc_d[7:0] = bus_in;
    else if (PCinc) pc_d[7:0] = pc_inc[7:0];
    if (PCHin)               pc_d[15:8] = bus_in;
    else if (PCinc && !PCLin) pc_d[15:8] = pc_inc[15:8];
  end

  // Fetch FSM next state: request latches the address, completion loads IR and pulses ir_valid
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (IRin) begin
          addr_d  = pc_q;
          rd_d    = 1'b1;
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_data;
          rd_d    = 1'b0;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == LAST) begin
          ir_d    = 8'h00;
          err_d   = 1'b1;
          rd_d    = 1'b0;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any fetch in flight and restores NOP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 8'h00;
      addr_q  <= RESET_VECTOR;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Bus driver: IRout > PCHout > PCLout
  always_comb begin
    bus_out = 8'h00;
    if (IRout)       bus_out = {4'h0, ir_q[3:0]};
    else if (PCHout) bus_out = pc_q[15:8];
    else if (PCLout) bus_out = pc_q[7:0];
  end

  assign bus_oe       = IRout | PCHout | PCLout;
  assign bus_conflict = (IRout & PCHout) | (IRout & PCLout) | (PCHout & PCLout);

  assign mem.mem_addr = addr_q;
  assign mem.mem_rd   = rd_q;
  assign fetch_busy   = rd_q;
  assign ir_valid     = valid_q;
  assign opcode       = ir_q[7:4];
  assign r1_sel       = ir_q[3:2];
  assign r2_sel       = ir_q[1:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       IRin, PCinc, PCHin, PCLin, PCHout, PCLout, IRout;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe, bus_conflict;
  logic [3:0] opcode;
  logic [1:0] r1_sel, r2_sel;
  logic       fetch_busy, ir_valid, fetch_err;

  instr_fetch_unit_if mif ();

  instr_fetch_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .IRin         (IRin),
    .PCinc        (PCinc),
    .PCHin        (PCHin),
    .PCLin        (PCLin),
    .PCHout       (PCHout),
    .PCLout       (PCLout),
    .IRout        (IRout),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .bus_conflict (bus_conflict),
    .mem          (mif.master),
    .opcode       (opcode),
    .r1_sel       (r1_sel),
    .r2_sel       (r2_sel),
    .fetch_busy   (fetch_busy),
    .ir_valid     (ir_valid),
    .fetch_err    (fetch_err)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        hin, lin, inc;
    logic [7:0]  bus;
    logic [15:0] exp_pc;
  } pc_vec_t;

  typedef struct {
    logic       irout, pchout, pclout;
    logic [7:0] exp_out;
    logic       exp_oe, exp_conf;
  } bus_vec_t;

  pc_vec_t  pcv[10];
  bus_vec_t bv[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_pc(output logic [15:0] pc);
    PCHout = 1'b1;
    #1 pc[15:8] = bus_out;
    PCHout = 1'b0;
    PCLout = 1'b1;
    #1 pc[7:0] = bus_out;
    PCLout = 1'b0;
    #1;
  endtask

  logic [15:0] pc;
  int          busy_cnt;

  initial begin
    pcv[0] = '{1, 1, 0, 8'hFF, 16'hFFFF};
    pcv[1] = '{0, 0, 1, 8'h00, 16'h0000};
    pcv[2] = '{0, 1, 0, 8'hFF, 16'h00FF};
    pcv[3] = '{0, 0, 1, 8'h00, 16'h0100};
    pcv[4] = '{0, 1, 1, 8'hFF, 16'h01FF};
    pcv[5] = '{1, 0, 1, 8'h12, 16'h1200};
    pcv[6] = '{1, 1, 1, 8'h34, 16'h3434};
    pcv[7] = '{0, 0, 0, 8'h55, 16'h3434};
    pcv[8] = '{1, 0, 0, 8'h12, 16'h1234};
    pcv[9] = '{0, 1, 0, 8'h34, 16'h1234};

    bv[0] = '{0, 0, 0, 8'h00, 0, 0};
    bv[1] = '{1, 0, 0, 8'h07, 1, 0};
    bv[2] = '{0, 1, 0, 8'h12, 1, 0};
    bv[3] = '{0, 0, 1, 8'h35, 1, 0};
    bv[4] = '{1, 0, 1, 8'h07, 1, 1};
    bv[5] = '{0, 1, 1, 8'h12, 1, 1};
    bv[6] = '{1, 1, 1, 8'h07, 1, 1};
    bv[7] = '{1, 1, 0, 8'h07, 1, 1};

    reset_n = 1'b0;
    {IRin, PCinc, PCHin, PCLin, PCHout, PCLout, IRout} = '0;
    bus_in = 8'h00;
    mif.mem_data  = 8'h00;
    mif.mem_ready = 1'b0;
    repeat (2) tick();

    check("rst_mem_rd",   16'(mif.mem_rd), 16'h0);
    check("rst_mem_addr", mif.mem_addr, 16'h0000);
    check("rst_busy",     16'(fetch_busy), 16'h0);
    check("rst_ir_valid", 16'(ir_valid), 16'h0);
    check("rst_err",      16'(fetch_err), 16'h0);
    check("rst_bus_oe",   16'(bus_oe), 16'h0);
    check("rst_bus_out",  16'(bus_out), 16'h0);
    check("rst_conflict", 16'(bus_conflict), 16'h0);
    check("rst_opcode",   16'(opcode), 16'h0);
    read_pc(pc);
    check("rst_pc", pc, 16'h0000);

    reset_n = 1'b1;
    tick();

    // basic fetch of 8'hD6 from address 0
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    check("f1_mem_rd",   16'(mif.mem_rd), 16'h1);
    check("f1_mem_addr", mif.mem_addr, 16'h0000);
    check("f1_busy",     16'(fetch_busy), 16'h1);
    check("f1_valid_early", 16'(ir_valid), 16'h0);
    mif.mem_ready = 1'b1;
    mif.mem_data  = 8'hD6;
    tick();
    mif.mem_ready = 1'b0;
    check("f1_ir_valid", 16'(ir_valid), 16'h1);
    check("f1_opcode",   16'(opcode), 16'hD);
    check("f1_r1",       16'(r1_sel), 16'h1);
    check("f1_r2",       16'(r2_sel), 16'h2);
    check("f1_mem_rd_off", 16'(mif.mem_rd), 16'h0);
    check("f1_busy_off", 16'(fetch_busy), 16'h0);
    tick();
    check("f1_valid_pulse", 16'(ir_valid), 16'h0);

    // PC update vectors
    for (int i = 0; i < 10; i++) begin
      PCHin  = pcv[i].hin;
      PCLin  = pcv[i].lin;
      PCinc  = pcv[i].inc;
      bus_in = pcv[i].bus;
      tick();
      {PCHin, PCLin, PCinc} = '0;
      read_pc(pc);
      check($sformatf("pc_vec%0d", i), pc, pcv[i].exp_pc);
    end

    // fetch at 0x1234 with delayed ready, IRin held and PCinc during WAIT
    IRin = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (fetch_busy) busy_cnt++;
      check($sformatf("w_addr%0d", i), mif.mem_addr, 16'h1234);
      PCinc = (i == 0);
      if (i == 3) begin
        mif.mem_ready = 1'b1;
        mif.mem_data  = 8'hC7;
      end
      tick();
    end
    mif.mem_ready = 1'b0;
    IRin = 1'b0;
    check("w_busy_cycles", 16'(busy_cnt), 16'd4);
    check("w_busy_off",    16'(fetch_busy), 16'h0);
    check("w_ir_valid",    16'(ir_valid), 16'h1);
    check("w_opcode",      16'(opcode), 16'hC);
    check("w_r1",          16'(r1_sel), 16'h1);
    check("w_r2",          16'(r2_sel), 16'h3);
    read_pc(pc);
    check("w_pc", pc, 16'h1235);
    tick();
    check("w_no_refetch", 16'(fetch_busy), 16'h0);

    // mem_ready while idle is ignored
    mif.mem_ready = 1'b1;
    mif.mem_data  = 8'hAB;
    tick();
    mif.mem_ready = 1'b0;
    check("idle_ready_valid",  16'(ir_valid), 16'h0);
    check("idle_ready_opcode", 16'(opcode), 16'hC);

    // bus output vectors, IR=C7, PC=1235
    for (int i = 0; i < 8; i++) begin
      IRout  = bv[i].irout;
      PCHout = bv[i].pchout;
      PCLout = bv[i].pclout;
      #1;
      check($sformatf("bus_out%0d", i),  16'(bus_out), 16'(bv[i].exp_out));
      check($sformatf("bus_oe%0d", i),   16'(bus_oe), 16'(bv[i].exp_oe));
      check($sformatf("bus_conf%0d", i), 16'(bus_conflict), 16'(bv[i].exp_conf));
    end
    {IRout, PCHout, PCLout} = '0;

    // reset during WAIT aborts the fetch at once
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    check("rw_mem_rd", 16'(mif.mem_rd), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rw_mem_rd_off", 16'(mif.mem_rd), 16'h0);
    check("rw_busy",       16'(fetch_busy), 16'h0);
    check("rw_opcode",     16'(opcode), 16'h0);
    read_pc(pc);
    check("rw_pc", pc, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef FETCH_TIMEOUT_EN
    // ready on the final allowed WAIT cycle is a success
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    repeat (7) tick();
    check("to_last_busy", 16'(fetch_busy), 16'h1);
    mif.mem_ready = 1'b1;
    mif.mem_data  = 8'hE5;
    tick();
    mif.mem_ready = 1'b0;
    check("to_last_valid",  16'(ir_valid), 16'h1);
    check("to_last_opcode", 16'(opcode), 16'hE);
    check("to_last_err",    16'(fetch_err), 16'h0);
    tick();
    // no ready at all: abort after 8 WAIT cycles
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    repeat (7) tick();
    check("to_pre_busy", 16'(fetch_busy), 16'h1);
    check("to_pre_err",  16'(fetch_err), 16'h0);
    tick();
    check("to_err",    16'(fetch_err), 16'h1);
    check("to_valid",  16'(ir_valid), 16'h1);
    check("to_opcode", 16'(opcode), 16'h0);
    check("to_mem_rd", 16'(mif.mem_rd), 16'h0);
    repeat (3) tick();
    check("to_err_sticky", 16'(fetch_err), 16'h1);
    reset_n = 1'b0;
    #1;
    check("to_err_clear", 16'(fetch_err), 16'h0);
    tick();
    reset_n = 1'b1;
    tick();
`else
    // without the timeout the fetch waits indefinitely
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    repeat (12) tick();
    check("nt_busy", 16'(fetch_busy), 16'h1);
    check("nt_err",  16'(fetch_err), 16'h0);
    mif.mem_ready = 1'b1;
    mif.mem_data  = 8'h3A;
    tick();
    mif.mem_ready = 1'b0;
    check("nt_valid",  16'(ir_valid), 16'h1);
    check("nt_opcode", 16'(opcode), 16'h3);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
